// File: rtl/ahb_lite_master.sv
// Single-beat AHB-Lite initiator: valid/ready commands in, pipelined NONSEQ transfers out.
// Optional stall detector enabled by defining AHB_MST_TIMEOUT_EN.
module ahb_lite_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  HSEL,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HRESP,
    output logic                  timeout
);

    logic                  a_valid;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic                  a_write;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  d_valid;
    logic                  d_write;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  err_q;

    logic advance;
    logic take;
    logic done;

    always_comb begin
        HSEL      = a_valid && !err_q;
        HTRANS    = HSEL ? 2'b10 : 2'b00;
        HADDR     = a_addr;
        HWRITE    = a_write;
        HSIZE     = 3'b010;
        HWDATA    = d_wdata;
        cmd_ready = !err_q && (!a_valid || HREADY);
        advance   = HREADY && !err_q;
        take      = cmd_valid && cmd_ready;
        done      = HREADY && d_valid;
    end

    // An empty A slot may be filled even during a wait state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_valid <= 1'b0;
            a_addr  <= '0;
            a_write <= 1'b0;
            a_wdata <= '0;
        end else if (take) begin
            a_valid <= 1'b1;
            a_addr  <= cmd_addr;
            a_write <= cmd_write;
            a_wdata <= cmd_wdata;
        end else if (advance) begin
            a_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            d_valid <= 1'b0;
            d_write <= 1'b0;
            d_wdata <= '0;
            err_q   <= 1'b0;
        end else if (err_q) begin
            if (HREADY) begin
                err_q   <= 1'b0;
                d_valid <= 1'b0;
            end
        end else if (advance) begin
            d_valid <= a_valid;
            d_write <= a_write;
            d_wdata <= a_wdata;
        end else if (d_valid && HRESP) begin
            err_q <= 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done;
            rsp_err   <= done && (err_q || HRESP);
            rsp_rdata <= (done && !d_write) ? HRDATA : '0;
        end
    end

`ifdef AHB_MST_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic          stall;
    logic [CW-1:0] stall_cnt;

    assign stall = d_valid && !HREADY;

    // Saturating at the threshold keeps the pulse to once per stall.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stall_cnt <= '0;
        end else if (!stall) begin
            stall_cnt <= '0;
        end else if (stall_cnt != CW'(TIMEOUT_CYCLES)) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

    assign timeout = stall && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomized bench for ahb_lite_master: behavioural AHB slave plus an
// in-order transaction model of expected responses.
module tb_ahb_lite_master;

    localparam int TO  = 4;
    localparam logic [31:0] BAD = 32'hBAD0_0000;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = '0;
    logic        HRESP = 1'b0;
    logic        timeout;

    ahb_lite_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HRESP(HRESP), .timeout(timeout)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a);
        return a[6] && (a[3:2] == 2'b00);
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mmem[16];
    logic [31:0] smem[16];
    int          cyc = 0;
    bit          lat_chk = 0;
    int          max_wait = 0;
    int          force_wait = -1;

    // Slave state
    bit          dp_v = 0;
    logic [31:0] dp_addr = '0;
    bit          dp_write = 0;
    bit          dp_err = 0;
    int          wait_left = 0;
    bit          err1 = 0;
    bit          err2 = 0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mmem[i] = '0;
            smem[i] = '0;
        end
    end

    // Behavioural slave: samples at posedge, drives at negedge
    initial begin
        forever begin
            @(posedge HCLK);
            if (!HRESETn) begin
                dp_v = 0;
                wait_left = 0;
                err1 = 0;
            end else if (HREADY) begin
                if (dp_v && dp_write && !dp_err)
                    smem[dp_addr[5:2]] = HWDATA;
                dp_v = HSEL && (HTRANS == 2'b10);
                dp_addr = HADDR;
                dp_write = HWRITE;
                dp_err = is_err(HADDR);
                wait_left = (force_wait >= 0) ? force_wait
                          : int'($urandom_range(0, max_wait));
                err1 = 0;
            end else if (wait_left > 0) begin
                wait_left--;
            end
            @(negedge HCLK);
            err2 = 0;
            if (!dp_v) begin
                HREADY = 1; HRESP = 0; HRDATA = $urandom;
            end else if (wait_left > 0) begin
                HREADY = 0; HRESP = 0; HRDATA = $urandom;
            end else if (dp_err) begin
                if (!err1) begin
                    HREADY = 0; HRESP = 1; err1 = 1; HRDATA = $urandom;
                end else begin
                    HREADY = 1; HRESP = 1; err2 = 1; HRDATA = BAD;
                end
            end else begin
                HREADY = 1; HRESP = 0;
                HRDATA = dp_write ? $urandom : smem[dp_addr[5:2]];
            end
        end
    end

    // Transaction model: one expected response per accepted command
    always @(posedge HCLK) begin
        exp_t e;
        cyc++;
        if (HRESETn && cmd_valid && cmd_ready) begin
            e.err = is_err(cmd_addr);
            e.acc = cyc;
            e.lat = lat_chk;
            if (cmd_write) begin
                e.rdata = '0;
                if (!e.err) mmem[cmd_addr[5:2]] = cmd_wdata;
            end else begin
                e.rdata = e.err ? BAD : mmem[cmd_addr[5:2]];
            end
            exp_q.push_back(e);
        end
    end

    int          run = 0;
    bit          p_hsel = 0;
    bit          p_hready = 1;
    logic [31:0] p_haddr = '0;
    logic [31:0] p_hwdata = '0;

    always @(negedge HCLK) begin
        exp_t e;
        bit   exp_to;
        #1;
        if (!HRESETn) begin
            run = 0;
            p_hsel = 0;
            p_hready = 1;
        end else begin
            check("hsize", 32'(HSIZE), 32'h2);
            if (err2) begin
                check("err_htrans", 32'(HTRANS), 32'h0);
                check("err_ready", 32'(cmd_ready), 32'h0);
            end
            if (!p_hready && p_hsel && HSEL)
                check("haddr_hold", HADDR, p_haddr);
            if (!p_hready)
                check("hwdata_hold", HWDATA, p_hwdata);
            if (dp_v && !HREADY) run++;
            else run = 0;
`ifdef AHB_MST_TIMEOUT_EN
            exp_to = (run == TO);
`else
            exp_to = 0;
`endif
            check("timeout", 32'(timeout), 32'(exp_to));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_spurious", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    if (e.lat) check("rsp_latency", 32'(cyc - e.acc), 32'h2);
                end
            end
            p_hsel = HSEL;
            p_hready = HREADY;
            p_haddr = HADDR;
            p_hwdata = HWDATA;
        end
    end

    task automatic issue(input logic [31:0] a, input logic w,
                         input logic [31:0] d);
        int n = 0;
        bit acc = 0;
        cmd_valid = 1;
        cmd_addr = a;
        cmd_write = w;
        cmd_wdata = d;
        while (!acc && n < 100) begin
            @(posedge HCLK);
            acc = cmd_ready;
            n++;
        end
        if (!acc) check("accept_timeout", 32'h0, 32'h1);
        #1;
        cmd_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge HCLK);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'h0);
        repeat (2) @(negedge HCLK);
    endtask

    initial begin
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_hsel", 32'(HSEL), 32'h0);
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_rsp", 32'(rsp_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        @(negedge HCLK);
        HRESETn = 1;
        repeat (2) @(negedge HCLK);

        max_wait = 0;
        issue(32'h0, 1, 32'hBEEF_BEEF);
        issue(32'h0, 0, 32'h0);
        drain();

        lat_chk = 1;
        issue(32'h4, 1, 32'hDEAD_BEEF);
        issue(32'h8, 1, 32'hBEEF_CAFE);
        drain();
        lat_chk = 0;

        force_wait = 3;
        issue(32'hC, 0, 32'h0);
        issue(32'h8, 0, 32'h0);
        @(negedge HCLK);
        #2;
        check("stall_ready", 32'(cmd_ready), 32'h0);
        drain();
        force_wait = -1;

        issue(32'h40, 1, 32'h1234_5678);
        issue(32'h44, 0, 32'h0);
        drain();

        force_wait = 6;
        issue(32'h10, 0, 32'h0);
        drain();

        force_wait = 5;
        issue(32'hC, 0, 32'h0);
        repeat (2) @(negedge HCLK);
        #3;
        HRESETn = 0;
        #1;
        check("mid_rst_hsel", 32'(HSEL), 32'h0);
        check("mid_rst_htrans", 32'(HTRANS), 32'h0);
        check("mid_rst_haddr", HADDR, 32'h0);
        check("mid_rst_hwdata", HWDATA, 32'h0);
        check("mid_rst_rsp", 32'(rsp_valid), 32'h0);
        exp_q.delete();
        repeat (2) @(negedge HCLK);
        HRESETn = 1;
        force_wait = -1;
        repeat (6) @(negedge HCLK);

        max_wait = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge HCLK);
                #1;
            end else begin
                issue({25'h0, 5'($urandom_range(0, 31)), 2'b00},
                      1'($urandom_range(0, 1)), $urandom);
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
